// File: rtl/div_seq_ctrl.sv
// Keypad-to-divider sequencer: assembles A/B from four nibbles, launches the divider,
// waits for done under a watchdog and drives the hex display. Option macro: DIV_ZERO_GUARD_EN.
module div_seq_ctrl #(
    parameter int DW          = 8,
    parameter int QW          = 7,
    parameter int RW          = 7,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    input  logic          key_clr,
    input  logic          div_busy,
    input  logic          div_done,
    input  logic [QW-1:0] div_q,
    input  logic [RW-1:0] div_r,
    output logic          div_start,
    output logic [DW-1:0] div_a,
    output logic [DW-1:0] div_b,
    output logic [15:0]   disp_value,
    output logic          res_valid,
    output logic          err,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        A_HI      = 3'd0,
        A_LO      = 3'd1,
        B_HI      = 3'd2,
        B_LO      = 3'd3,
        START     = 3'd4,
        WAIT_DONE = 3'd5,
        SHOW      = 3'd6
    } state_e;

    localparam int            CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [QW-1:0]   q_q, q_d;
    logic [RW-1:0]   r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_q, start_d;
    logic            res_valid_q, res_valid_d;
    logic            err_q, err_d;
    logic            dz_q, dz_d;
    logic            zero_guard;

`ifdef DIV_ZERO_GUARD_EN
    assign zero_guard = (b_q == '0);
`else
    assign zero_guard = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        q_d         = q_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        start_d     = 1'b0;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        dz_d        = dz_q;

        if (key_clr) begin
            state_d     = A_HI;
            a_d         = '0;
            b_d         = '0;
            res_valid_d = 1'b0;
            err_d       = 1'b0;
            dz_d        = 1'b0;
        end else begin
            unique case (state_q)
                A_HI: if (key_valid) begin
                    a_d            = '0;
                    a_d[DW-1 -: 4] = key_code;
                    state_d        = A_LO;
                end
                A_LO: if (key_valid) begin
                    a_d[3:0] = key_code;
                    state_d  = B_HI;
                end
                B_HI: if (key_valid) begin
                    b_d            = '0;
                    b_d[DW-1 -: 4] = key_code;
                    state_d        = B_LO;
                end
                B_LO: if (key_valid) begin
                    b_d[3:0] = key_code;
                    state_d  = START;
                end
                START: begin
                    if (zero_guard) begin
                        err_d   = 1'b1;
                        dz_d    = 1'b1;
                        state_d = SHOW;
                    end else if (!div_busy) begin
                        start_d = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (div_done) begin
                        q_d         = div_q;
                        r_d         = div_r;
                        res_valid_d = 1'b1;
                        err_d       = 1'b0;
                        state_d     = SHOW;
                    end else if (cnt_q == CNT_LAST) begin
                        err_d       = 1'b1;
                        res_valid_d = 1'b0;
                        state_d     = SHOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHOW: if (key_valid) begin
                    a_d            = '0;
                    a_d[DW-1 -: 4] = key_code;
                    b_d            = '0;
                    res_valid_d    = 1'b0;
                    err_d          = 1'b0;
                    dz_d           = 1'b0;
                    state_d        = A_LO;
                end
                default: state_d = A_HI;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= A_HI;
            a_q         <= '0;
            b_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            q_q         <= q_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            dz_q        <= dz_d;
        end
    end

    // Display is a pure decode of registered state, so it follows reset immediately.
    always_comb begin
        disp_value = {a_q[7:0], b_q[7:0]};
        if (state_q == SHOW) begin
            if (res_valid_q) begin
                disp_value = {8'(q_q), 8'(r_q)};
            end else if (err_q) begin
                disp_value = dz_q ? 16'hD1F0 : 16'hEEEE;
            end
        end
    end

    assign div_start = start_q;
    assign div_a     = a_q;
    assign div_b     = b_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule
